// File: rtl/uart_rx_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_pkg
// Shared types and constants for the serial receive control stage.
//   rx_state_t        : receive FSM states (IDLE, START, DATA, STOP)
//   CLKS_PER_BIT_DEF  : default clocks per serial bit
//   DATA_BITS_DEF     : default data bits per frame
//   CNT_BITS          : width of the bit-period timer
//   BIT_CNT_W         : width of the data-bit counter (holds 0..8)
// -----------------------------------------------------------------------------
package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int CLKS_PER_BIT_DEF = 10;
  localparam int DATA_BITS_DEF    = 8;
  localparam int CNT_BITS         = 8;
  localparam int BIT_CNT_W        = 4;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl_if
// Bundles the receive stage's line input and host-side word/flag outputs.
//   serial_in     : synchronized serial line, idle high   (master -> slave)
//   data_read     : host acknowledge                      (master -> slave)
//   rx_data       : last good received word               (slave -> master)
//   data_ready    : rx_data holds an unread word          (slave -> master)
//   framing_error : last completed frame had stop bit = 0 (slave -> master)
//   overrun_error : unread word was overwritten           (slave -> master)
// The slave modport is the receiver; the master modport is the line/host side.
// -----------------------------------------------------------------------------
interface uart_rx_ctrl_if
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF
) ();

  logic                 serial_in;
  logic                 data_read;
  logic [DATA_BITS-1:0] rx_data;
  logic                 data_ready;
  logic                 framing_error;
  logic                 overrun_error;

  modport master (
    output serial_in,
    output data_read,
    input  rx_data,
    input  data_ready,
    input  framing_error,
    input  overrun_error
  );

  modport slave (
    input  serial_in,
    input  data_read,
    output rx_data,
    output data_ready,
    output framing_error,
    output overrun_error
  );

endinterface

// File: rtl/flex_counter.sv
// -----------------------------------------------------------------------------
// flex_counter
// Programmable up-counter: counts 0,1..rollover_val then wraps to 1.
//   clk           : system clock, rising edge
//   n_rst         : asynchronous active-low reset
//   clear         : synchronous clear to 0 (priority over count_enable)
//   count_enable  : advance the count this edge
//   rollover_val  : terminal count
//   count_out     : current count
//   rollover_flag : high while count_out == rollover_val
// -----------------------------------------------------------------------------
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);

  logic [NUM_CNT_BITS-1:0] count_q, count_d;
  logic                    flag_q, flag_d;

  // Count and flag registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
      flag_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      flag_q  <= flag_d;
    end
  end

  // Next count; the flag is registered so it lines up with the count value.
  always_comb begin
    count_d = count_q;
    flag_d  = flag_q;
    if (clear) begin
      count_d = '0;
      flag_d  = 1'b0;
    end else if (count_enable) begin
      if (count_q == rollover_val) begin
        count_d = {{(NUM_CNT_BITS-1){1'b0}}, 1'b1};
      end else begin
        count_d = count_q + 1'b1;
      end
      flag_d = (count_d == rollover_val);
    end else begin
      count_d = count_q;
      flag_d  = flag_q;
    end
  end

  assign count_out     = count_q;
  assign rollover_flag = flag_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl
// Serial receive control: detects a start bit, samples DATA_BITS data bits
// mid-bit LSB-first, checks the stop bit and presents the word with flags.
// A flex_counter is the bit-period timer: held clear in IDLE, free-running
// otherwise, sampling at count == CLKS_PER_BIT/2 and advancing on rollover.
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : uart_rx_ctrl_if.slave (serial_in, data_read in; rx_data,
//         data_ready, framing_error, overrun_error out, all registered)
// -----------------------------------------------------------------------------
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DATA_BITS    = DATA_BITS_DEF
) (
  input  logic          clk,
  input  logic          rst,
  uart_rx_ctrl_if.slave bus
);

  localparam logic [CNT_BITS-1:0]  ROLLOVER = CNT_BITS'(CLKS_PER_BIT);
  localparam logic [CNT_BITS-1:0]  MID      = CNT_BITS'(CLKS_PER_BIT / 2);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_BITS);

  rx_state_t              state_q, state_d;
  logic                   prev_serial_q, prev_serial_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
  logic                   data_ready_q, data_ready_d;
  logic                   framing_error_q, framing_error_d;
  logic                   overrun_error_q, overrun_error_d;

  logic                   start_edge_s;
  logic                   sample_s;
  logic                   advance_s;
  logic                   timer_clear_s;
  logic                   timer_en_s;
  logic [CNT_BITS-1:0]    count_s;
  logic                   rollover_s;
  logic                   stop_ok_s;
  logic                   stop_bad_s;

  // Bit-period timer.
  flex_counter #(
    .NUM_CNT_BITS(CNT_BITS)
  ) u_timer (
    .clk          (clk),
    .n_rst        (~rst),
    .clear        (timer_clear_s),
    .count_enable (timer_en_s),
    .rollover_val (ROLLOVER),
    .count_out    (count_s),
    .rollover_flag(rollover_s)
  );

  assign start_edge_s  = prev_serial_q & ~bus.serial_in;
  assign sample_s      = (count_s == MID);
  assign advance_s     = rollover_s;
  assign timer_clear_s = (state_q == IDLE);
  assign timer_en_s    = (state_q != IDLE);
  assign prev_serial_d = bus.serial_in;

  // State, shifter and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      prev_serial_q   <= 1'b1;
      shift_q         <= '0;
      bit_cnt_q       <= '0;
      rx_data_q       <= '0;
      data_ready_q    <= 1'b0;
      framing_error_q <= 1'b0;
      overrun_error_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      prev_serial_q   <= prev_serial_d;
      shift_q         <= shift_d;
      bit_cnt_q       <= bit_cnt_d;
      rx_data_q       <= rx_data_d;
      data_ready_q    <= data_ready_d;
      framing_error_q <= framing_error_d;
      overrun_error_q <= overrun_error_d;
    end
  end

  // Receive FSM next state, data shifter and bit counter.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_ok_s  = 1'b0;
    stop_bad_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_edge_s) begin
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        // Line back high at mid start bit means a glitch, not a frame.
        if (sample_s && bus.serial_in) begin
          state_d = IDLE;
        end else if (advance_s) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        // New bit enters at the MSB so the first bit ends up in bit 0.
        if (sample_s) begin
          shift_d = {bus.serial_in, shift_q[DATA_BITS-1:1]};
        end else begin
          shift_d = shift_q;
        end
        if (advance_s) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_d == LAST_BIT) begin
            state_d = STOP;
          end else begin
            state_d = DATA;
          end
        end else begin
          state_d = DATA;
        end
      end
      STOP: begin
        // Leave at mid stop bit so an immediately following start is seen.
        if (sample_s) begin
          state_d = IDLE;
          if (bus.serial_in) begin
            stop_ok_s = 1'b1;
          end else begin
            stop_bad_s = 1'b1;
          end
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Host-visible word and status flags.
  always_comb begin
    rx_data_d       = rx_data_q;
    data_ready_d    = data_ready_q;
    framing_error_d = framing_error_q;
    overrun_error_d = overrun_error_q;
    if (bus.data_read) begin
      data_ready_d    = 1'b0;
      overrun_error_d = 1'b0;
    end else begin
      data_ready_d    = data_ready_q;
      overrun_error_d = overrun_error_q;
    end
    // A completing word wins over a same-cycle acknowledge.
    if (stop_ok_s) begin
      rx_data_d       = shift_q;
      data_ready_d    = 1'b1;
      framing_error_d = 1'b0;
      if (data_ready_q && !bus.data_read) begin
        overrun_error_d = 1'b1;
      end else begin
        overrun_error_d = overrun_error_d;
      end
    end else if (stop_bad_s) begin
      framing_error_d = 1'b1;
    end else begin
      framing_error_d = framing_error_q;
    end
  end

  assign bus.rx_data       = rx_data_q;
  assign bus.data_ready    = data_ready_q;
  assign bus.framing_error = framing_error_q;
  assign bus.overrun_error = overrun_error_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_ctrl
// Self-checking bench for uart_rx_ctrl at CLKS_PER_BIT=10, DATA_BITS=8.
// Frames are driven bit-exact on the line; good words are queued when driven
// and compared by a monitor when the DUT presents them.
// -----------------------------------------------------------------------------
module tb_uart_rx_ctrl;
  import uart_rx_pkg::*;

  localparam int N    = 10;
  localparam int DB   = 8;
  localparam int MIDV = N / 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  uart_rx_ctrl_if #(.DATA_BITS(DB)) bus ();

  uart_rx_ctrl #(
    .CLKS_PER_BIT(N),
    .DATA_BITS   (DB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       do_read;
    logic [7:0] exp_rx;
    logic       exp_rdy;
    logic       exp_fe;
    logic       exp_ov;
  } vec_t;

  vec_t       vecs[7];
  int         chk_cnt   = 0;
  int         pass_cnt  = 0;
  int         edge_cnt  = 0;
  int         e_idx     = 0;
  int         rise_edge = -1;
  logic [7:0] sb_q[$];
  logic [7:0] exp_w;
  logic       rdy_prev  = 1'b0;
  logic [7:0] rx_prev   = 8'h00;

  // Running edge index used for latency measurement.
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard monitor: a new word is a data_ready rise or a changed rx_data.
  always @(negedge clk) begin
    if (!rst && bus.data_ready && (!rdy_prev || bus.rx_data != rx_prev)) begin
      rise_edge = edge_cnt;
      if (sb_q.size() == 0) begin
        check("sb_unexpected_word", int'(bus.rx_data), -1);
      end else begin
        exp_w = sb_q.pop_front();
        check("sb_word", int'(bus.rx_data), int'(exp_w));
      end
    end
    rdy_prev = bus.data_ready;
    rx_prev  = bus.rx_data;
  end

  task automatic check_outs(input string tag, input int rx, input int rdy,
                            input int fe, input int ov);
    check({tag, "_rx_data"},       int'(bus.rx_data),       rx);
    check({tag, "_data_ready"},    int'(bus.data_ready),    rdy);
    check({tag, "_framing_error"}, int'(bus.framing_error), fe);
    check({tag, "_overrun_error"}, int'(bus.overrun_error), ov);
  endtask

  // Drive one frame, each bit held N edges; abort_bit pulses rst mid-bit.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int abort_bit);
    bus.serial_in = 1'b0;
    @(posedge clk); #1 e_idx = edge_cnt;
    repeat (N - 1) @(posedge clk);
    #1;
    for (int i = 0; i < DB; i++) begin
      bus.serial_in = d[i];
      if (i == abort_bit) begin
        repeat (MIDV) @(posedge clk);
        #1 rst = 1'b1;
        #2;
        check_outs("rst_mid_frame", 0, 0, 0, 0);
        check("rst_mid_frame_state", int'(dut.state_q), int'(IDLE));
        @(posedge clk); #1 rst = 1'b0;
        repeat (N - MIDV - 1) @(posedge clk);
        #1;
      end else begin
        repeat (N) @(posedge clk);
        #1;
      end
    end
    bus.serial_in = stop;
    repeat (N) @(posedge clk);
    #1 bus.serial_in = 1'b1;
  endtask

  task automatic read_pulse(input string tag);
    bus.data_read = 1'b1;
    @(posedge clk); #1 bus.data_read = 1'b0;
    check({tag, "_read_rdy"}, int'(bus.data_ready), 0);
    check({tag, "_read_ov"},  int'(bus.overrun_error), 0);
  endtask

  initial begin
    vecs[0] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h55, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{8'h12, 1'b1, 1'b1, 8'h12, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'h02, 1'b1, 1'b1, 8'h02, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{8'h77, 1'b1, 1'b0, 8'h77, 1'b1, 1'b0, 1'b0};

    rst           = 1'b1;
    bus.serial_in = 1'b1;
    bus.data_read = 1'b0;
    #12;
    check_outs("reset", 0, 0, 0, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #2;
    check_outs("idle_reset", 0, 0, 0, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    check_outs("idle50", 0, 0, 0, 0);
    check("idle50_state", int'(dut.state_q), int'(IDLE));
    check("idle50_timer", int'(dut.u_timer.count_out), 0);

    // False start: 3 low cycles are rejected at the mid-start sample.
    bus.serial_in = 1'b0;
    @(posedge clk); #1;
    check("false_start_enter", int'(dut.state_q), int'(START));
    repeat (2) @(posedge clk);
    #1 bus.serial_in = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("false_start_state", int'(dut.state_q), int'(IDLE));
    check("false_start_rdy", int'(bus.data_ready), 0);

    for (int v = 0; v < 7; v++) begin
      if (vecs[v].stop) sb_q.push_back(vecs[v].data);
      send_frame(vecs[v].data, vecs[v].stop, -1);
      check_outs($sformatf("vec%0d", v), int'(vecs[v].exp_rx), int'(vecs[v].exp_rdy),
                 int'(vecs[v].exp_fe), int'(vecs[v].exp_ov));
      if (v == 1) check("latency_a5", rise_edge - e_idx, MIDV + 1 + N * (DB + 1));
      if (vecs[v].do_read) begin
        read_pulse($sformatf("vec%0d", v));
        repeat (2) @(posedge clk);
        #1;
      end else if (!vecs[v].stop) begin
        repeat (3) @(posedge clk);
        #1;
      end
    end

    // Reset during data bit 4 with an unread word pending.
    send_frame(8'hF0, 1'b1, 4);
    repeat (20) @(posedge clk);
    #1;
    check_outs("after_abort", 0, 0, 0, 0);
    check("after_abort_state", int'(dut.state_q), int'(IDLE));

    sb_q.push_back(8'hFF);
    send_frame(8'hFF, 1'b1, -1);
    check_outs("frame_ff", 8'hFF, 1, 0, 0);
    read_pulse("frame_ff");
    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", sb_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Serial receive control stage built around one flex_counter instance used as its bit-period timer.
- Drives the timer's clear and count_enable inputs, and consumes its count_out and rollover_flag outputs.
- Detects start bits, samples data mid-bit LSB-first, checks the stop bit, and presents a parallel byte with ready and error flags.
- Sits between the input synchronizer and the receive FIFO/host interface.

Parameters:
- CLKS_PER_BIT, 10, clocks per serial bit; legal range 4..255; timer rollover_val.
- DATA_BITS, 8, data bits per frame; legal range 5..8.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- serial_in  in  1  already-synchronized serial line; idle high.
- data_read  in  1  host acknowledge; clears data_ready and overrun_error.
- rx_data  out  DATA_BITS  last good received word.
- data_ready  out  1  rx_data holds an unread word.
- framing_error  out  1  last completed frame had stop bit = 0.
- overrun_error  out  1  unread word was overwritten.

Behaviour:
- Reset values:
  - rx_data = 0; data_ready = 0; framing_error = 0; overrun_error = 0.
  - State = IDLE; prev_serial = 1; shift register = 0; bit counter = 0; timer count = 0.
- start_edge = prev_serial & ~serial_in. prev_serial is registered every clock.
- Timer (flex_counter):
  - clear = 1 in IDLE; count_enable = 1 in every non-IDLE state.
  - Counts 0,1..CLKS_PER_BIT, then wraps to 1. rollover_flag is high while count == CLKS_PER_BIT.
- MID = CLKS_PER_BIT/2 (integer division).
- Sample edge = a clock edge at which count_out == MID.
- Advance edge = a clock edge at which rollover_flag == 1.
- States:
  - IDLE: start_edge -> START.
  - START:
    - Sample edge with serial_in = 1 -> IDLE. This is a false start; no flags change.
    - Advance edge -> DATA, bit counter = 0.
  - DATA:
    - Sample edge: shift right; serial_in enters the MSB of a DATA_BITS-wide register, giving LSB-first order.
    - Advance edge: bit counter += 1. When it reaches DATA_BITS -> STOP.
  - STOP: sample edge -> IDLE. Return at mid-stop-bit so back-to-back frames are caught.
- STOP sample with serial_in = 1:
  - rx_data <= shift register; data_ready <= 1; framing_error <= 0.
  - If data_ready was already 1 and data_read = 0 this cycle: overrun_error <= 1.
- STOP sample with serial_in = 0:
  - framing_error <= 1; rx_data and data_ready unchanged.
- data_read = 1: data_ready <= 0 and overrun_error <= 0 next edge.
- data_read coinciding with a valid stop sample: the new word wins; data_ready = 1, no overrun.
- Latency, start_edge registered at edge E, N = CLKS_PER_BIT:
  - Data bit i sampled at edge E + MID + 1 + N*(i+1).
  - data_ready visible after edge E + MID + 1 + N*(DATA_BITS+1). For N=10, DATA_BITS=8 this is E+96.
- rst mid-frame: immediate return to reset values, including clearing a pending unread word.
- serial_in held low in IDLE without a new falling edge does not restart reception.

Decomposition:
- Package uart_rx_pkg:
  - rx_state_t enum {IDLE, START, DATA, STOP}.
  - Default constants CLKS_PER_BIT_DEF = 10 and DATA_BITS_DEF = 8.
- One sub-module: flex_counter (existing block, reused unmodified), NUM_CNT_BITS = 8.
- The existing flex_counter has an active-low reset (n_rst). Connect .n_rst(~rst) at the instantiation.
- FSM, edge detect, shifter and flag logic live in uart_rx_ctrl.

Test Plan:
- Assert rst mid-idle, then release -> all outputs 0; state IDLE; no activity with serial_in = 1 for 50 cycles.
- Frame 0xA5 (start, bits 1,0,1,0,0,1,0,1 LSB-first, stop = 1) at N=10 -> rx_data = 8'hA5, data_ready = 1 after E+96, framing_error = 0.
- serial_in low for 3 cycles then high -> returns to IDLE at START sample; data_ready stays 0; next valid 0x3C frame received correctly.
- Frame 0x55 with stop bit = 0 -> framing_error = 1, data_ready = 0, rx_data unchanged. A following valid 0x12 frame -> framing_error = 0, rx_data = 8'h12.
- Two back-to-back frames 0x01 then 0x02 with no data_read -> rx_data = 8'h02, overrun_error = 1. data_read pulse -> data_ready = 0, overrun_error = 0.
- rst pulsed during DATA bit 4 of a frame -> outputs return to 0 immediately. The remainder of that frame yields no data_ready; next full frame 0xFF received correctly.
